// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_pkg
// Description : Shared constants, FSM encoding and byte classification for
//               the PS/2 keyboard receive path.
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_PAUSE  = 8'hE1;
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    localparam logic [1:0] RX_IDLE   = 2'd0;
    localparam logic [1:0] RX_DATA   = 2'd1;
    localparam logic [1:0] RX_PARITY = 2'd2;
    localparam logic [1:0] RX_STOP   = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = RX_IDLE,
        DATA   = RX_DATA,
        PARITY = RX_PARITY,
        STOP   = RX_STOP
    } ps2_rx_state_t;

    // Device responses and error codes that never describe a key.
    function automatic logic is_response(input logic [7:0] b);
        return (b == 8'hFA) || (b == 8'hAA) || (b == 8'hEE) ||
               (b == 8'hFE) || (b == 8'h00) || (b == 8'hFF);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_key_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : ps2_key_decoder_if
// Description : PS/2 line inputs and keyboard event outputs of the decoder.
// Revision    : 1.0 - initial release
// ============================================================================
interface ps2_key_decoder_if;

    logic       ps2_clk;
    logic       ps2_dat;
    logic       key_strobe;
    logic       key_pressed;
    logic       key_extended;
    logic [7:0] key_code;
    logic       frame_err;

    modport master (
        input  ps2_clk, ps2_dat,
        output key_strobe, key_pressed, key_extended, key_code, frame_err
    );

    modport slave (
        output ps2_clk, ps2_dat,
        input  key_strobe, key_pressed, key_extended, key_code, frame_err
    );

endinterface
`default_nettype wire

// File: rtl/ps2_frame_rx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_frame_rx
// Description : Synchronises and filters the PS/2 lines, assembles 11-bit
//               frames and reports good bytes or frame errors.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 65536
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic       byte_vld,
    output logic [7:0] rx_byte,
    output logic       frame_err
);

    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int TW  = $clog2(TIMEOUT_CYC + 1);

    // Bit 0 carries the clock line, bit 1 the data line.
    logic [1:0] raw_w;
    logic [1:0] sync0_q;
    logic [1:0] sync1_q;
    logic [1:0] filt_w;

    assign raw_w = {ps2_dat, ps2_clk};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync0_q <= 2'b11;
            sync1_q <= 2'b11;
        end else begin
            sync0_q <= raw_w;
            sync1_q <= sync0_q;
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_filter
        logic [FCW-1:0] cnt_q;
        logic [FCW-1:0] cnt_d;
        logic           val_q;
        logic           val_d;

        // Any sample agreeing with the current output restarts the run.
        always_comb begin
            cnt_d = '0;
            val_d = val_q;
            if (sync1_q[i] != val_q) begin
                if (cnt_q == FCW'(FILTER_LEN - 1)) begin
                    val_d = sync1_q[i];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt_q <= '0;
                val_q <= 1'b1;
            end else begin
                cnt_q <= cnt_d;
                val_q <= val_d;
            end
        end

        assign filt_w[i] = val_q;
    end

    logic clk_prev_q;
    logic fall_w;
    logic dat_w;

    assign fall_w = clk_prev_q & ~filt_w[0];
    assign dat_w  = filt_w[1];

    ps2_rx_state_t state_q, state_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          vld_q, vld_d;
    logic          err_q, err_d;

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        par_d    = par_q;
        vld_d    = 1'b0;
        err_d    = 1'b0;
        if (state_q == IDLE || fall_w) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + 1'b1;
        end

        if (fall_w) begin
            case (state_q)
                IDLE: begin
                    if (!dat_w) begin
                        state_d  = DATA;
                        bitcnt_d = '0;
                    end
                end
                DATA: begin
                    shift_d  = {dat_w, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 1'b1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    par_d   = dat_w;
                    state_d = STOP;
                end
                STOP: begin
                    if (dat_w && ((^shift_q) ^ par_q)) begin
                        vld_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE && timer_q == TW'(TIMEOUT_CYC - 1)) begin
            state_d = IDLE;
            err_d   = 1'b1;
            timer_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_prev_q <= 1'b1;
            state_q    <= IDLE;
            bitcnt_q   <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            timer_q    <= '0;
            vld_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            clk_prev_q <= filt_w[0];
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            timer_q    <= timer_d;
            vld_q      <= vld_d;
            err_q      <= err_d;
        end
    end

    // The shifter is untouched until the next start bit, so it can be the byte.
    assign byte_vld  = vld_q;
    assign rx_byte   = shift_q;
    assign frame_err = err_q;

endmodule
`default_nettype wire

// File: rtl/ps2_key_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ps2_key_decoder
// Description : Turns received PS/2 bytes into make/break key events,
//               stripping E0/F0 prefixes and swallowing the Pause sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 65536
) (
    input  logic              clk,
    input  logic              reset_n,
    ps2_key_decoder_if.master bus
);

    logic       byte_vld;
    logic [7:0] rx_byte;
    logic       frame_err;

    ps2_frame_rx #(
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx (
        .clk       (clk),
        .reset_n   (reset_n),
        .ps2_clk   (bus.ps2_clk),
        .ps2_dat   (bus.ps2_dat),
        .byte_vld  (byte_vld),
        .rx_byte   (rx_byte),
        .frame_err (frame_err)
    );

    logic [2:0] skip_q, skip_d;
    logic       ext_q, ext_d;
    logic       brk_q, brk_d;
    logic       strobe_q, strobe_d;
    logic [7:0] code_q, code_d;
    logic       pressed_q, pressed_d;
    logic       extended_q, extended_d;

    // Frame errors never reach here, so pending prefixes survive a bad byte.
    always_comb begin
        skip_d     = skip_q;
        ext_d      = ext_q;
        brk_d      = brk_q;
        strobe_d   = 1'b0;
        code_d     = code_q;
        pressed_d  = pressed_q;
        extended_d = extended_q;
        if (byte_vld) begin
            if (skip_q != 3'd0) begin
                skip_d = skip_q - 1'b1;
            end else if (rx_byte == PS2_PAUSE) begin
                skip_d = PAUSE_SKIP;
            end else if (rx_byte == PS2_EXT) begin
                ext_d = 1'b1;
            end else if (rx_byte == PS2_BRK) begin
                brk_d = 1'b1;
            end else if (!is_response(rx_byte)) begin
                strobe_d   = 1'b1;
                code_d     = rx_byte;
                pressed_d  = ~brk_q;
                extended_d = ext_q;
                ext_d      = 1'b0;
                brk_d      = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            skip_q     <= '0;
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            strobe_q   <= 1'b0;
            code_q     <= '0;
            pressed_q  <= 1'b0;
            extended_q <= 1'b0;
        end else begin
            skip_q     <= skip_d;
            ext_q      <= ext_d;
            brk_q      <= brk_d;
            strobe_q   <= strobe_d;
            code_q     <= code_d;
            pressed_q  <= pressed_d;
            extended_q <= extended_d;
        end
    end

    assign bus.key_strobe   = strobe_q;
    assign bus.key_pressed  = pressed_q;
    assign bus.key_extended = extended_q;
    assign bus.key_code     = code_q;
    assign bus.frame_err    = frame_err;

endmodule
`default_nettype wire
